// File: rtl/router_pkg.sv
// Shared definitions for the router input-port packetiser.
// Contents:
//   HDR_TYPE          - 4-bit type code placed in the top nibble of every header
//   *_MSB / *_LSB     - bit positions of the header fields
//   encap_state_t     - packetiser FSM state encoding
package router_pkg;

    localparam logic [3:0] HDR_TYPE = 4'hA;

    localparam int TTL_MSB    = 8;
    localparam int TTL_LSB    = 7;
    localparam int PKTNUM_MSB = 6;
    localparam int PKTNUM_LSB = 2;
    localparam int SRC_MSB    = 1;
    localparam int SRC_LSB    = 0;
    localparam int DST_LSB    = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } encap_state_t;

endpackage

// File: rtl/input_port0_encap_if.sv
// Bundle of the packetiser's handshake and bus signals.
//   slave  : view of the packetiser itself
//   master : view of the environment (memory reader + router controller)
// Signals:
//   dfx_valid/dfx_data/dfx_last/dfx_ready      - upstream payload stream
//   ready_encap_dfx                            - header request pulse
//   header_pkt_send/router_dst_addr_send       - header fields returned by the controller
//   rd_input_port_0/empty_input_port_0         - FIFO pop / empty toward the controller
//   port0_data/port0_data_valid                - popped word
//   pkt_count                                  - packets completely written
interface input_port0_encap_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic              dfx_valid;
    logic [DATA_W-1:0] dfx_data;
    logic              dfx_last;
    logic              dfx_ready;
    logic              ready_encap_dfx;
    logic [8:0]        header_pkt_send;
    logic [ADDR_W-1:0] router_dst_addr_send;
    logic              rd_input_port_0;
    logic              empty_input_port_0;
    logic [DATA_W-1:0] port0_data;
    logic              port0_data_valid;
    logic [15:0]       pkt_count;

    modport slave (
        input  dfx_valid, dfx_data, dfx_last, header_pkt_send,
               router_dst_addr_send, rd_input_port_0,
        output dfx_ready, ready_encap_dfx, empty_input_port_0,
               port0_data, port0_data_valid, pkt_count
    );

    modport master (
        output dfx_valid, dfx_data, dfx_last, header_pkt_send,
               router_dst_addr_send, rd_input_port_0,
        input  dfx_ready, ready_encap_dfx, empty_input_port_0,
               port0_data, port0_data_valid, pkt_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-based full/empty and a registered read port.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push, din         - write request and data (ignored while full)
//   pop               - read request (ignored while empty)
//   dout, dout_valid  - popped word, valid for one cycle after an effective pop
//   full, empty, count- occupancy
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             push_eff;
    logic             pop_eff;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;

    // Both gates use the occupancy registered before this cycle, so a push
    // into a full FIFO is dropped even if a pop happens on the same edge.
    assign push_eff = push && !full;
    assign pop_eff  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= pop_eff;
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                dout_reg   <= mem[rd_ptr_reg];
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/input_port0_encap.sv
// Packetiser in front of router input port 0. For each packet it requests a
// header from the router controller, writes the header word and then up to
// MAX_PAYLOAD_WORDS payload words into an internal FIFO, which the controller
// drains through the empty flag / read strobe.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - input_port0_encap_if.slave (payload stream, header
//                request/response, FIFO read side, packet counter)
module input_port0_encap
    import router_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH        = 10,
    parameter int FIFO_DEPTH        = 16,
    parameter int MAX_PAYLOAD_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_port0_encap_if.slave   bus
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PCW = $clog2(MAX_PAYLOAD_WORDS + 1);

    encap_state_t                 state_reg;
    logic [PCW-1:0]               pay_cnt_reg;
    logic                         req_reg;
    logic [15:0]                  pkt_count_reg;

    logic                         fifo_push;
    logic [AURORA_DATA_WIDTH-1:0] fifo_din;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CW-1:0]                fifo_count;
    logic [AURORA_DATA_WIDTH-1:0] header_word;
    logic                         dfx_ready;
    logic                         payload_fire;

    // Header: type nibble on top, destination above the 9-bit
    // {TTL, pkt_num, src} field, which is copied verbatim.
    always_comb begin
        header_word = '0;
        header_word[AURORA_DATA_WIDTH-1 -: 4]     = HDR_TYPE;
        header_word[DST_LSB +: ADDR_WIDTH]        = bus.router_dst_addr_send;
        header_word[TTL_MSB:TTL_LSB]              = bus.header_pkt_send[TTL_MSB:TTL_LSB];
        header_word[PKTNUM_MSB:PKTNUM_LSB]        = bus.header_pkt_send[PKTNUM_MSB:PKTNUM_LSB];
        header_word[SRC_MSB:SRC_LSB]              = bus.header_pkt_send[SRC_MSB:SRC_LSB];
    end

    assign dfx_ready    = (state_reg == PAYLOAD) && !fifo_full;
    assign payload_fire = bus.dfx_valid && dfx_ready;

    // The IDLE admission check leaves room for the header, so the HDR write
    // never meets a full FIFO.
    assign fifo_push = (state_reg == HDR) || payload_fire;
    assign fifo_din  = (state_reg == HDR) ? header_word : bus.dfx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pay_cnt_reg   <= '0;
            req_reg       <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.dfx_valid && (fifo_count <= CW'(FIFO_DEPTH - 2))) begin
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                // Controller registers the header during this cycle.
                REQ: state_reg <= HDR;
                HDR: begin
                    pay_cnt_reg <= '0;
                    state_reg   <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (payload_fire) begin
                        pay_cnt_reg <= pay_cnt_reg + 1'b1;
                        if (bus.dfx_last || (pay_cnt_reg == PCW'(MAX_PAYLOAD_WORDS - 1))) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    pkt_count_reg <= pkt_count_reg + 16'd1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (AURORA_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .din        (fifo_din),
        .pop        (bus.rd_input_port_0),
        .dout       (bus.port0_data),
        .dout_valid (bus.port0_data_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign bus.dfx_ready          = dfx_ready;
    assign bus.ready_encap_dfx    = req_reg;
    assign bus.empty_input_port_0 = fifo_empty;
    assign bus.pkt_count          = pkt_count_reg;
endmodule

// File: tb/tb_input_port0_encap.sv
// Self-checking bench for input_port0_encap. A scoreboard queue mirrors the
// FIFO contents: headers are queued when the bench answers a header request,
// payload words when a stream handshake completes, and entries are popped and
// compared whenever port0_data_valid is seen.
module tb_input_port0_encap;

    logic clk;
    logic rst_n;

    input_port0_encap_if #(.DATA_W(64), .ADDR_W(10)) bus ();

    input_port0_encap dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];
    logic [63:0] stream_data[$];
    bit          stream_last[$];
    int          idx, accepted, popped, pulses, hdr_n;
    bit          rdy_s, empty_s, rd_s, req_prev, hdr_cycle, gaps;
    int          pop_mode;
    logic [63:0] held;
    logic [8:0]  hdr_base, cur_hdr;
    logic [9:0]  dst_base, cur_dst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] make_hdr(input logic [8:0] h, input logic [9:0] d);
        return {4'hA, 41'd0, d, h};
    endfunction

    task automatic drive_pop(input int mode);
        pop_mode = mode;
        bus.rd_input_port_0 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        rd_s = bus.rd_input_port_0;
    endtask

    task automatic tick();
        logic [63:0] exp_w;
        bit hdr_now;
        @(posedge clk);
        #1;
        // Account for what happened at the edge just passed.
        if (hdr_cycle) begin
            q.push_back(make_hdr(cur_hdr, cur_dst));
            hdr_cycle = 0;
        end
        if (bus.dfx_valid && rdy_s) begin
            q.push_back(bus.dfx_data);
            idx++;
            accepted++;
        end
        chk("rd_valid", 64'(bus.port0_data_valid), 64'(rd_s && !empty_s));
        if (bus.port0_data_valid) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 64'(q.size() + 1), 64'd0);
            end else begin
                exp_w = q.pop_front();
                chk("data", bus.port0_data, exp_w);
                popped++;
                $display("pop %0d data=%h", popped, bus.port0_data);
            end
            held = bus.port0_data;
        end else begin
            chk("data_hold", bus.port0_data, held);
        end
        chk("empty", 64'(bus.empty_input_port_0), 64'(q.size() == 0));
        // Router controller model: answer a request on the following cycle.
        hdr_now = req_prev;
        if (bus.ready_encap_dfx) begin
            chk("req_pulse", 64'(req_prev), 64'd0);
            pulses++;
        end
        req_prev = bus.ready_encap_dfx;
        if (hdr_now) begin
            cur_hdr = hdr_base + 9'(hdr_n);
            cur_dst = dst_base + 10'(hdr_n * 7);
            hdr_n++;
            bus.header_pkt_send      = cur_hdr;
            bus.router_dst_addr_send = cur_dst;
            hdr_cycle = 1;
        end else begin
            bus.header_pkt_send      = 9'($urandom);
            bus.router_dst_addr_send = 10'($urandom);
        end
        rdy_s   = bus.dfx_ready;
        empty_s = bus.empty_input_port_0;
        if (idx < stream_data.size() && !(gaps && $urandom_range(0, 3) == 0)) begin
            bus.dfx_valid = 1'b1;
            bus.dfx_data  = stream_data[idx];
            bus.dfx_last  = stream_last[idx];
        end else begin
            bus.dfx_valid = 1'b0;
            bus.dfx_data  = {$urandom, $urandom};
            bus.dfx_last  = 1'b0;
        end
        drive_pop(pop_mode);
    endtask

    task automatic clear_model();
        q.delete();
        stream_data.delete();
        stream_last.delete();
        idx = 0; accepted = 0; popped = 0; pulses = 0; hdr_n = 0;
        rdy_s = 0; empty_s = 1; req_prev = 0; hdr_cycle = 0; gaps = 0;
        held = '0;
        bus.dfx_valid = 1'b0;
        bus.dfx_last  = 1'b0;
        bus.dfx_data  = '0;
        drive_pop(0);
    endtask

    // Asserts reset immediately (asynchronously) and checks reset values.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_dfx_ready", 64'(bus.dfx_ready), 64'd0);
        chk("rst_req", 64'(bus.ready_encap_dfx), 64'd0);
        chk("rst_empty", 64'(bus.empty_input_port_0), 64'd1);
        chk("rst_data", bus.port0_data, 64'd0);
        chk("rst_valid", 64'(bus.port0_data_valid), 64'd0);
        chk("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_stream(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            stream_data.push_back({$urandom, $urandom});
            stream_last.push_back(i == last_at - 1);
        end
    endtask

    task automatic run_stream(input int budget);
        int n = 0;
        while (idx < stream_data.size() && n < budget) begin
            tick();
            n++;
        end
        chk("stream_timeout", 64'(idx), 64'(stream_data.size()));
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        drive_pop(1);
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_left", 64'(q.size()), 64'd0);
        drive_pop(0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        bus.header_pkt_send      = '0;
        bus.router_dst_addr_send = '0;
        clear_model();

        // Single packet, 3 words.
        do_reset();
        hdr_base = 9'h10A; dst_base = 10'h155;
        load_stream(3, 3);
        run_stream(50);
        chk("t1_pkt_count", 64'(bus.pkt_count), 64'd1);
        chk("t1_pulses", 64'(pulses), 64'd1);
        drain(50);
        chk("t1_popped", 64'(popped), 64'd4);

        // Forced packet break after 8 payload words, with valid gaps.
        do_reset();
        hdr_base = 9'h0C1; dst_base = 10'h2F3; gaps = 1;
        load_stream(10, 10);
        run_stream(200);
        chk("t2_pkt_count", 64'(bus.pkt_count), 64'd2);
        chk("t2_pulses", 64'(pulses), 64'd2);
        drain(50);
        chk("t2_popped", 64'(popped), 64'd12);

        // Backpressure: no pops until the FIFO fills.
        do_reset();
        hdr_base = 9'h055; dst_base = 10'h001;
        load_stream(20, 20);
        for (int i = 0; i < 60; i++) tick();
        chk("t3_accepted", 64'(accepted), 64'd14);
        chk("t3_ready_full", 64'(bus.dfx_ready), 64'd0);
        chk("t3_not_empty", 64'(bus.empty_input_port_0), 64'd0);
        drive_pop(2);
        run_stream(400);
        drain(100);
        chk("t3_popped", 64'(popped), 64'd23);
        chk("t3_pulses", 64'(pulses), 64'd3);
        chk("t3_pkt_count", 64'(bus.pkt_count), 64'd3);

        // Pop on empty, then concurrent push+pop at occupancy 5.
        do_reset();
        hdr_base = 9'h1F0; dst_base = 10'h3AA;
        drive_pop(1);
        for (int i = 0; i < 5; i++) tick();
        drive_pop(0);
        load_stream(20, 20);
        n = 0;
        while (accepted < 4 && n < 50) begin
            tick();
            n++;
        end
        chk("t4_fill", 64'(accepted), 64'd4);
        drive_pop(1);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_steady", 64'(q.size()), 64'd5);
        run_stream(200);
        drain(100);
        chk("t4_pkt_count", 64'(bus.pkt_count), 64'd3);

        // Reset in the middle of a packet, then a clean packet.
        do_reset();
        hdr_base = 9'h033; dst_base = 10'h099;
        load_stream(5, 5);
        n = 0;
        while (accepted < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_mid", 64'(accepted), 64'd2);
        do_reset();
        hdr_base = 9'h1AB; dst_base = 10'h0CD;
        load_stream(2, 2);
        run_stream(50);
        chk("t5_pkt_count", 64'(bus.pkt_count), 64'd1);
        drain(50);
        chk("t5_popped", 64'(popped), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
